mem_burst_ctrl: RTL

- Burst sequencer placed directly upstream of the 16-bit-address / 32-bit-data `memory` block. Drives that block's `address_dec`, `data_in`, `rwn` and `start` pins, and consumes its `data_out`.
- Accepts one burst command at a time (base address, length, direction) over a valid/ready handshake.
- Write bursts: streams write words into consecutive addresses.
- Read bursts: issues one read address per cycle and returns the read words as a valid-qualified stream.

---
 rtl/mem_burst_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer in front of the 16-bit-address / 32-bit-data memory block.
// Takes one burst command at a time and streams write words or read words over consecutive addresses.
module mem_burst_ctrl #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned LEN_W        = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rwn,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_rwn,
  output logic              mem_start,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam int unsigned CW = LEN_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t                  state, state_n;
  logic [ADDR_W-1:0]       base_q, base_n;
  logic [LEN_W-1:0]        len_q, len_n;
  logic [CW-1:0]           count, count_n;
  logic [READ_LATENCY-1:0] vpipe, vpipe_n;
  logic [CW-1:0]           words;
  logic [ADDR_W-1:0]       cur_addr;

  logic                    mem_start_n;
  logic                    mem_rwn_n;
  logic [ADDR_W-1:0]       mem_address_n;
  logic [DATA_W-1:0]       mem_data_in_n;
  logic                    rd_valid_n;
  logic [DATA_W-1:0]       rd_data_n;
  logic                    done_n;

  assign words     = CW'(len_q) + CW'(1);
  assign cur_addr  = base_q + ADDR_W'(count);

  assign cmd_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);
  assign wr_ready  = (state == WRITE) && (count < words);

  always_comb begin
    state_n       = state;
    base_n        = base_q;
    len_n         = len_q;
    count_n       = count;
    mem_start_n   = 1'b0;
    mem_rwn_n     = 1'b1;
    mem_address_n = mem_address;
    mem_data_in_n = mem_data_in;
    done_n        = 1'b0;

    // Valid pipeline tracks each registered read strobe until its word is on mem_data_out.
    vpipe_n       = READ_LATENCY'({vpipe, mem_start && mem_rwn});
    rd_valid_n    = vpipe[READ_LATENCY-1];
    rd_data_n     = vpipe[READ_LATENCY-1] ? mem_data_out : rd_data;

    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          base_n  = cmd_addr;
          len_n   = cmd_len;
          count_n = '0;
          state_n = cmd_rwn ? READ : WRITE;
        end
      end
      WRITE: begin
        // count == words only in the cycle carrying the final strobe.
        if (count == words) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else if (wr_valid && wr_ready) begin
          mem_start_n   = 1'b1;
          mem_rwn_n     = 1'b0;
          mem_address_n = cur_addr;
          mem_data_in_n = wr_data;
          count_n       = count + CW'(1);
        end
      end
      READ: begin
        mem_start_n   = 1'b1;
        mem_rwn_n     = 1'b1;
        mem_address_n = cur_addr;
        count_n       = count + CW'(1);
        if (count == CW'(len_q)) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (!mem_start && (vpipe == '0)) begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      count       <= '0;
      vpipe       <= '0;
      mem_start   <= 1'b0;
      mem_rwn     <= 1'b1;
      mem_address <= '0;
      mem_data_in <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      base_q      <= base_n;
      len_q       <= len_n;
      count       <= count_n;
      vpipe       <= vpipe_n;
      mem_start   <= mem_start_n;
      mem_rwn     <= mem_rwn_n;
      mem_address <= mem_address_n;
      mem_data_in <= mem_data_in_n;
      rd_valid    <= rd_valid_n;
      rd_data     <= rd_data_n;
      done        <= done_n;
    end
  end

endmodule
